// File: rtl/boolean_sweep_ctrl.sv
// Self-test sequencer for the 4-input boolean circuit E = A + BC + B'D, F = B'C + BC'D'.
// Sweeps all 16 vectors and builds truth-table maps and ones-counts. Define SWEEP_CHECK_EN for golden compare.
module boolean_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        e_in,
    input  logic        f_in,
    output logic        a_out,
    output logic        b_out,
    output logic        c_out,
    output logic        d_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] e_map,
    output logic [15:0] f_map,
    output logic [4:0]  e_count,
    output logic [4:0]  f_count,
    output logic        err_flag,
    output logic [3:0]  err_index
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  index_reg;
    logic [3:0]  settle_cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] e_map_reg;
    logic [15:0] f_map_reg;
    logic [4:0]  e_count_reg;
    logic [4:0]  f_count_reg;
    logic        err_flag_reg;
    logic [3:0]  err_index_reg;
    logic        mismatch;

`ifdef SWEEP_CHECK_EN
    logic [15:0] golden_e;
    logic [15:0] golden_f;

    // Golden truth tables are built per vector index at elaboration.
    for (genvar gi = 0; gi < 16; gi++) begin : g_golden
        localparam logic [3:0] IDX = 4'(gi);
        assign golden_e[gi] = IDX[3] | (IDX[2] & IDX[1]) | (~IDX[2] & IDX[0]);
        assign golden_f[gi] = (~IDX[2] & IDX[1]) | (IDX[2] & ~IDX[1] & ~IDX[0]);
    end

    assign mismatch = (e_in != golden_e[index_reg]) || (f_in != golden_f[index_reg]);
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            index_reg      <= 4'd0;
            settle_cnt_reg <= 4'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            e_map_reg      <= 16'd0;
            f_map_reg      <= 16'd0;
            e_count_reg    <= 5'd0;
            f_count_reg    <= 5'd0;
            err_flag_reg   <= 1'b0;
            err_index_reg  <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start && !abort) begin
                        state_reg      <= SETTLE;
                        index_reg      <= 4'd0;
                        settle_cnt_reg <= 4'd0;
                        busy_reg       <= 1'b1;
                        e_map_reg      <= 16'd0;
                        f_map_reg      <= 16'd0;
                        e_count_reg    <= 5'd0;
                        f_count_reg    <= 5'd0;
                        err_flag_reg   <= 1'b0;
                        err_index_reg  <= 4'd0;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state_reg      <= IDLE;
                        index_reg      <= 4'd0;
                        settle_cnt_reg <= 4'd0;
                        busy_reg       <= 1'b0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 4'd1;
                        if (settle_cnt_reg == SETTLE_LAST) begin
                            state_reg <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    // An abort in the sample cycle discards this vector's result.
                    if (abort) begin
                        state_reg      <= IDLE;
                        index_reg      <= 4'd0;
                        settle_cnt_reg <= 4'd0;
                        busy_reg       <= 1'b0;
                    end else begin
                        e_map_reg[index_reg] <= e_in;
                        f_map_reg[index_reg] <= f_in;
                        e_count_reg          <= e_count_reg + {4'd0, e_in};
                        f_count_reg          <= f_count_reg + {4'd0, f_in};
                        if (mismatch && !err_flag_reg) begin
                            err_flag_reg  <= 1'b1;
                            err_index_reg <= index_reg;
                        end
                        settle_cnt_reg <= 4'd0;
                        if (index_reg == 4'd15) begin
                            state_reg <= DONE;
                            index_reg <= 4'd0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= SETTLE;
                            index_reg <= index_reg + 4'd1;
                        end
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out     = index_reg[3];
    assign b_out     = index_reg[2];
    assign c_out     = index_reg[1];
    assign d_out     = index_reg[0];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign e_map     = e_map_reg;
    assign f_map     = f_map_reg;
    assign e_count   = e_count_reg;
    assign f_count   = f_count_reg;
    assign err_flag  = err_flag_reg;
    assign err_index = err_index_reg;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Directed bench for boolean_sweep_ctrl: two instances (settle 1 and 3) driving a behavioural
// model of the boolean circuit, with hand-computed truth-table expectations.
module tb_boolean_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, force_e0;
    logic start1, abort1, start3, abort3;
    logic a1, b1, c1, d1, busy1, done1, err1;
    logic a3, b3, c3, d3, busy3, done3, err3;
    logic e1, f1, e3, f3;
    logic [15:0] emap1, fmap1, emap3, fmap3;
    logic [4:0]  ecnt1, fcnt1, ecnt3, fcnt3;
    logic [3:0]  eidx1, eidx3;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt1 = 0;

    function automatic logic ckt_e(input logic [3:0] v);
        return v[3] | (v[2] & v[1]) | (~v[2] & v[0]);
    endfunction

    function automatic logic ckt_f(input logic [3:0] v);
        return (~v[2] & v[1]) | (v[2] & ~v[1] & ~v[0]);
    endfunction

    wire [3:0] idx1 = {a1, b1, c1, d1};
    wire [3:0] idx3 = {a3, b3, c3, d3};
    assign e1 = force_e0 ? 1'b0 : ckt_e(idx1);
    assign f1 = ckt_f(idx1);
    assign e3 = ckt_e(idx3);
    assign f3 = ckt_f(idx3);

    boolean_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .e_in(e1), .f_in(f1),
        .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1), .busy(busy1), .done(done1),
        .e_map(emap1), .f_map(fmap1), .e_count(ecnt1), .f_count(fcnt1),
        .err_flag(err1), .err_index(eidx1)
    );

    boolean_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .e_in(e3), .f_in(f3),
        .a_out(a3), .b_out(b3), .c_out(c3), .d_out(d3), .busy(busy3), .done(done3),
        .e_map(emap3), .f_map(fmap3), .e_count(ecnt3), .f_count(fcnt3),
        .err_flag(err3), .err_index(eidx3)
    );

    always @(negedge clk) begin
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit sel3, input int limit, output int cycles);
        cycles = -1;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if ((sel3 ? done3 : done1) === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, idx1_at, first_done, base_cnt, hits;
        logic [31:0] exp_err;

        rst = 1'b1; force_e0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        repeat (2) tick();
        check("reset_ctl", {28'd0, busy1, done1, err1, 1'b0}, 32'd0);
        check("reset_idx", {24'd0, idx1, eidx1}, 32'd0);
        check("reset_maps", {emap1, fmap1}, 32'd0);
        check("reset_cnts", {22'd0, ecnt1, fcnt1}, 32'd0);
        rst = 1'b0;
        tick();

        // Correct circuit, settle 1.
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("s1_busy", {31'd0, busy1}, 32'd1);
        wait_done(1'b0, 200, lat);
        check("s1_latency", lat, 32);
        check("s1_done_outs", {27'd0, busy1, idx1}, 32'd0);
        check("s1_e_map", emap1, 32'hFFCA);
        check("s1_f_map", fmap1, 32'h1C1C);
        check("s1_counts", {22'd0, ecnt1, fcnt1}, {22'd0, 5'd12, 5'd6});
        check("s1_err", {27'd0, err1, eidx1}, 32'd0);
        $display("[TB] sweep settle=1 latency=%0d e_map=%h f_map=%h", lat, emap1, fmap1);
        tick();
        check("s1_done_pulse", {31'd0, done1}, 32'd0);
        check("s1_hold", {emap1, fmap1}, 32'hFFCA_1C1C);

        // Settle 3: vector 0 held through 3 settle cycles plus the sample cycle.
        start3 = 1'b1; tick(); start3 = 1'b0;
        idx1_at = -1;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (idx1_at < 0 && idx3 == 4'd1) idx1_at = n;
            if (done3 === 1'b1) begin lat = n; break; end
        end
        check("s3_hold_cycles", idx1_at, 4);
        check("s3_latency", lat, 64);
        check("s3_maps", {emap3, fmap3}, 32'hFFCA_1C1C);
        check("s3_counts", {22'd0, ecnt3, fcnt3}, {22'd0, 5'd12, 5'd6});
        $display("[TB] sweep settle=3 latency=%0d e_map=%h f_map=%h", lat, emap3, fmap3);
        tick();

        // Second start mid-sweep is ignored.
        base_cnt = done_cnt1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        first_done = -1;
        for (int n = 1; n <= 80; n++) begin
            if (n == 10) start1 = 1'b1;
            if (n == 11) start1 = 1'b0;
            tick();
            if (first_done < 0 && done1 === 1'b1) first_done = n;
        end
        tick();
        check("restart_latency", first_done, 32);
        check("restart_pulses", done_cnt1 - base_cnt, 1);
        $display("[TB] restart-ignored sweep done at %0d pulses=%0d", first_done, done_cnt1 - base_cnt);

        // Abort while vector 5 is on the circuit.
        base_cnt = done_cnt1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        hits = 0;
        for (int n = 0; n < 100; n++) begin
            if (idx1 == 4'd5) begin hits = 1; break; end
            tick();
        end
        check("abort_reach_idx5", hits, 1);
        abort1 = 1'b1; tick(); abort1 = 1'b0;
        check("abort_outs", {27'd0, busy1, idx1}, 32'd0);
        repeat (40) tick();
        check("abort_no_done", done_cnt1 - base_cnt, 0);
        check("abort_maps", {emap1, fmap1}, 32'h000A_001C);
        check("abort_counts", {22'd0, ecnt1, fcnt1}, {22'd0, 5'd2, 5'd3});
        $display("[TB] abort at idx5 e_map=%h e_count=%0d", emap1, ecnt1);

        // Reset in the middle of a sweep, then a clean sweep.
        start1 = 1'b1; tick(); start1 = 1'b0;
        hits = 0;
        for (int n = 0; n < 100; n++) begin
            if (idx1 == 4'd9) begin hits = 1; break; end
            tick();
        end
        check("rst_reach_idx9", hits, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_ctl", {24'd0, busy1, done1, err1, 1'b0, idx1}, 32'd0);
        check("midrst_maps", {emap1, fmap1}, 32'd0);
        check("midrst_cnts", {22'd0, ecnt1, fcnt1}, 32'd0);
        tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_done(1'b0, 200, lat);
        check("post_rst_latency", lat, 32);
        check("post_rst_maps", {emap1, fmap1}, 32'hFFCA_1C1C);
        $display("[TB] sweep after mid-sweep reset e_map=%h f_map=%h", emap1, fmap1);
        tick();

        // Faulty circuit: E stuck at 0.
        force_e0 = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_done(1'b0, 200, lat);
        check("stuck_latency", lat, 32);
        check("stuck_maps", {emap1, fmap1}, 32'h0000_1C1C);
        check("stuck_counts", {22'd0, ecnt1, fcnt1}, {22'd0, 5'd0, 5'd6});
`ifdef SWEEP_CHECK_EN
        exp_err = {27'd0, 1'b1, 4'd1};
`else
        exp_err = 32'd0;
`endif
        check("stuck_err", {27'd0, err1, eidx1}, exp_err);
        $display("[TB] sweep with E stuck-at-0 err_flag=%0b err_index=%0d", err1, eidx1);
        force_e0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
